fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle MIPS core. Issues word reads to a handshaked instruction memory, buffers returned words with their PCs in a small in-order queue, and presents them to the core through a valid/ready interface. A redirect input (branch target from the core's `pcsrc`/`pcbranch` path) flushes the queue and restarts fetch at the new PC, discarding any read already in flight.

---
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request channel and the core-facing instruction channel.
// The master modport is the fetch unit's view; the slave modport is the memory/core environment.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rdata, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word read at a time, returned words queued in order
// with their PCs, redirect flushes the queue and restarts fetch at the new PC.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       bus,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   addr, addr_next;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic          push, pop, room;

    assign bus.mem_req    = (state == REQ) || (state == DROP);
    assign bus.mem_addr   = addr;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = inst_q[rd_ptr];
    assign bus.inst_pc    = pc_q[rd_ptr];

    assign push = (state == REQ) && bus.mem_ack && !redirect;
    assign pop  = bus.inst_valid && bus.inst_ready && !redirect;

    always_comb begin
        if (redirect)
            count_next = '0;
        else
            count_next = count + (push ? CW'(1) : '0) - (pop ? CW'(1) : '0);
    end

    assign room = (count_next < CW'(DEPTH));

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = addr;
        if (redirect)
            fetch_pc_next = redirect_pc & ~32'h3;
        unique case (state)
            IDLE: begin
                if (!redirect && room) begin
                    state_next = REQ;
                    addr_next  = fetch_pc;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (redirect) begin
                        state_next = IDLE;
                    end else begin
                        fetch_pc_next = addr + 32'd4;
                        if (room)
                            addr_next = addr + 32'd4;
                        else
                            state_next = IDLE;
                    end
                end else if (redirect) begin
                    // Request stays on the bus; its response must be swallowed.
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr     <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            addr     <= addr_next;
            count    <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    pc_q[wr_ptr]   <= addr;
                    inst_q[wr_ptr] <= bus.mem_rdata;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based reference model of fetch behaviour and a
// variable-latency memory whose data word is address ^ 32'hA5A5_0000.
module tb_fetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PAT      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queued PCs, next fetch PC, the PC on the bus, and whether a
    // request is outstanding / its response is to be thrown away.
    logic [31:0] pcq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_drop;
    int          lat;
    int          wait_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pcq.delete();
        m_fetch_pc = RESET_PC;
        m_addr     = RESET_PC;
        m_busy     = 0;
        m_drop     = 0;
        wait_cnt   = 0;
    endtask

    task automatic model_step(input bit rd, input logic [31:0] rpc, input bit ack, input bit rdy);
        bit push, pop;
        push = m_busy && !m_drop && ack && !rd;
        pop  = (pcq.size() != 0) && rdy && !rd;
        if (rd) begin
            pcq.delete();
            m_fetch_pc = rpc & ~32'h3;
        end else begin
            if (pop) void'(pcq.pop_front());
            if (push) pcq.push_back(m_addr);
        end
        if (!m_busy) begin
            if (!rd && pcq.size() < DEPTH) begin
                m_busy = 1;
                m_addr = m_fetch_pc;
            end
        end else if (m_drop) begin
            if (ack) begin
                m_busy = 0;
                m_drop = 0;
            end
        end else if (ack) begin
            if (rd) begin
                m_busy = 0;
            end else begin
                m_fetch_pc = m_addr + 32'd4;
                if (pcq.size() < DEPTH) m_addr = m_addr + 32'd4;
                else m_busy = 0;
            end
        end else if (rd) begin
            m_drop = 1;
        end
    endtask

    // Called at a falling edge: compare outputs, drive this cycle's inputs, advance one clock.
    task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
        bit ack, req;
        check("mem_req", 32'(bus.mem_req), 32'(m_busy));
        if (m_busy) check("mem_addr", bus.mem_addr, m_addr);
        check("inst_valid", 32'(bus.inst_valid), 32'(pcq.size() != 0));
        if (pcq.size() != 0) begin
            check("inst_pc", bus.inst_pc, pcq[0]);
            check("inst", bus.inst, pcq[0] ^ PAT);
        end
        req = bus.mem_req;
        ack = req && (wait_cnt >= lat);
        bus.mem_ack    = ack;
        bus.mem_rdata  = ack ? (bus.mem_addr ^ PAT) : $urandom;
        bus.inst_ready = rdy;
        redirect       = rd;
        redirect_pc    = rpc;
        model_step(rd, rpc, ack, rdy);
        @(posedge clk);
        if (req && ack) wait_cnt = 0;
        else if (req) wait_cnt++;
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, RESET_PC);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
    endtask

    task automatic wait_fresh_request(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.mem_req && m_busy && !m_drop && wait_cnt == 0) begin
                found = 1;
                break;
            end
            step(1, 0, '0);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        bit found;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        bus.inst_ready = 1'b0;
        lat = 0;
        model_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // Zero-wait memory, core always ready: one instruction per cycle.
        repeat (10) step(1, 0, '0);

        // Core stalls: queue fills, fetch stops; a single pop restarts it.
        repeat (8) step(0, 0, '0);
        step(1, 0, '0);
        repeat (4) step(0, 0, '0);

        // Slow memory, redirect while a request is pending.
        lat = 3;
        wait_fresh_request("setup_drop1");
        step(1, 1, 32'h0000_0100);
        repeat (10) step(1, 0, '0);

        // Two redirects while the discarded response is still pending.
        wait_fresh_request("setup_drop2");
        step(1, 1, 32'h0000_0040);
        step(1, 1, 32'h0000_0080);
        repeat (10) step(1, 0, '0);

        // Redirect coinciding with ack and pop, unaligned target.
        lat = 0;
        repeat (6) step(1, 0, '0);
        step(1, 1, 32'h0000_0203);
        repeat (5) step(1, 0, '0);

        // PC wrap-around at the top of the address space.
        step(1, 1, 32'hFFFF_FFF8);
        repeat (6) step(1, 0, '0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit rdy, rd;
            logic [31:0] rpc;
            if (i % 100 == 0) lat = $urandom_range(0, 3);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(rdy, rd, rpc);
        end

        // Reset asserted mid-request with two entries queued.
        lat = 3;
        step(0, 1, 32'h0000_1000);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (pcq.size() == 2 && bus.mem_req && m_busy && !m_drop) begin
                found = 1;
                break;
            end
            step(0, 0, '0);
        end
        check("setup_reset", 32'(found), 32'd1);
        bus.mem_ack = 1'b0;
        redirect    = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_mem_req", 32'(bus.mem_req), 32'd0);
        check("async_inst_valid", 32'(bus.inst_valid), 32'd0);
        model_reset();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        lat = 0;
        repeat (8) step(1, 0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
